serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor computing DIFF = A − B − Bin one bit per clock, LSB first, through a single full-subtractor cell. It is the inverse-operation companion to the team's ripple-carry adder. It trades latency for area and is used in datapaths where a start/ready/valid handshake fronts the arithmetic. Operands are captured on start; the result, the borrow-out and the signed-overflow flag are held until the next result replaces them.

---
 rtl/serial_subtractor_if.sv | 40 ++++
 rtl/serial_subtractor.sv | 131 +++++++++++++
 tb/tb_serial_subtractor.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The requester (master) drives start and the operands; the subtractor
// (slave) returns ready, the registered result flags and the valid pulse.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
) ();
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             ready;
    logic [WIDTH-1:0] DIFF;
    logic             Bout;
    logic             ovf;
    logic             valid;

    modport master (
        output start,
        output A,
        output B,
        output Bin,
        input  ready,
        input  DIFF,
        input  Bout,
        input  ovf,
        input  valid
    );

    modport slave (
        input  start,
        input  A,
        input  B,
        input  Bin,
        output ready,
        output DIFF,
        output Bout,
        output ovf,
        output valid
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - Bin, one bit per clock, LSB first,
// through a single full-subtractor cell.
//
//   state | meaning
//   IDLE  | ready=1, waiting for start; operands captured on accept
//   RUN   | one operand bit per edge; bit counter counts down to zero
//   DONE  | valid=1 for one cycle, results already loaded; back to IDLE
//
// Results (DIFF/Bout/ovf) are loaded only on the edge that enters DONE and
// hold through later IDLE cycles. Every output is a flop, so nothing from
// the bus inputs reaches the outputs combinationally.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             ovf_q;
    logic             valid_q;
    logic             ready_q;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    // Full-subtractor cell on the current LSBs plus the result shift-in.
    always_comb begin
        a_bit    = a_sh[0];
        b_bit    = b_sh[0];
        d_bit    = a_bit ^ b_bit ^ br;
        br_next  = (~a_bit & b_bit) | (~a_bit & br) | (b_bit & br);
        res_next = {d_bit, res_sh[WIDTH-1:1]};
        last_bit = (cnt == '0);
    end

    // Sequencer, datapath shift registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            br      <= 1'b0;
            cnt     <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.start) begin
                        a_sh    <= bus.A;
                        b_sh    <= bus.B;
                        br      <= bus.Bin;
                        res_sh  <= '0;
                        cnt     <= CNT_LOAD;
                        ready_q <= 1'b0;
                        state   <= RUN;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end

                RUN: begin
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    res_sh <= res_next;
                    br     <= br_next;
                    if (last_bit) begin
                        // On the MSB edge br still holds the borrow into the
                        // MSB, so overflow is that borrow XOR the borrow out.
                        diff_q  <= res_next;
                        bout_q  <= br_next;
                        ovf_q   <= br ^ br_next;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                DONE: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    cnt     <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.DIFF  = diff_q;
    assign bus.Bout  = bout_q;
    assign bus.ovf   = ovf_q;
    assign bus.valid = valid_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4) with hand-computed vectors.
module tb_serial_subtractor;

    localparam int WIDTH = 4;
    localparam int MAX_WAIT = 20;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operation and waits for valid; returns edges from the
    // accepting edge (counted as 1) to the first cycle showing valid=1.
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic bin, output int lat,
                         output logic [WIDTH-1:0] d, output logic bo,
                         output logic ov);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Bin   = bin;
        tick();
        lat       = 1;
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.B     = ~b;
        bus.Bin   = ~bin;
        while (bus.valid !== 1'b1 && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
        d  = bus.DIFF;
        bo = bus.Bout;
        ov = bus.ovf;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bin   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.ready !== 1'b1 || bus.valid !== 1'b0 || bus.DIFF !== 4'b0000 ||
                bus.Bout !== 1'b0 || bus.ovf !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: ready=%b valid=%b DIFF=%b Bout=%b ovf=%b, expected 1 0 0000 0 0",
                         i, bus.ready, bus.valid, bus.DIFF, bus.Bout, bus.ovf);
            end
            tick();
        end
    endtask

    task automatic test_basic();
        int lat;
        logic [WIDTH-1:0] d;
        logic bo, ov;
        do_op(4'b0101, 4'b0011, 1'b0, lat, d, bo, ov);
        checks++;
        if (lat !== 5) begin
            errors++;
            $display("FAIL basic_latency: got %0d edges, expected 5", lat);
        end
        checks++;
        if (d !== 4'b0010 || bo !== 1'b0 || ov !== 1'b0 || bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: DIFF=%b Bout=%b ovf=%b ready=%b, expected 0010 0 0 0", d, bo, ov, bus.ready);
        end
        tick();
        checks++;
        if (bus.valid !== 1'b0 || bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_valid_pulse: valid=%b ready=%b, expected 0 1", bus.valid, bus.ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.DIFF !== 4'b0010 || bus.Bout !== 1'b0 || bus.ovf !== 1'b0 || bus.valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_hold cycle %0d: DIFF=%b Bout=%b ovf=%b valid=%b, expected 0010 0 0 0",
                         i, bus.DIFF, bus.Bout, bus.ovf, bus.valid);
            end
        end
    endtask

    task automatic test_borrow();
        int lat;
        logic [WIDTH-1:0] d;
        logic bo, ov;
        do_op(4'b0000, 4'b0001, 1'b0, lat, d, bo, ov);
        checks++;
        if (lat !== 5 || d !== 4'b1111 || bo !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL borrow_0_minus_1: lat=%0d DIFF=%b Bout=%b ovf=%b, expected 5 1111 1 0", lat, d, bo, ov);
        end
        tick();
        do_op(4'b1111, 4'b1111, 1'b1, lat, d, bo, ov);
        checks++;
        if (lat !== 5 || d !== 4'b1111 || bo !== 1'b1 || ov !== 1'b0) begin
            errors++;
            $display("FAIL borrow_f_minus_f_bin: lat=%0d DIFF=%b Bout=%b ovf=%b, expected 5 1111 1 0", lat, d, bo, ov);
        end
        tick();
    endtask

    task automatic test_overflow();
        int lat;
        logic [WIDTH-1:0] d;
        logic bo, ov;
        do_op(4'b1010, 4'b0101, 1'b1, lat, d, bo, ov);
        checks++;
        if (lat !== 5 || d !== 4'b0100 || bo !== 1'b0 || ov !== 1'b1) begin
            errors++;
            $display("FAIL ovf_neg: lat=%0d DIFF=%b Bout=%b ovf=%b, expected 5 0100 0 1", lat, d, bo, ov);
        end
        tick();
        do_op(4'b0111, 4'b1000, 1'b0, lat, d, bo, ov);
        checks++;
        if (lat !== 5 || d !== 4'b1111 || bo !== 1'b1 || ov !== 1'b1) begin
            errors++;
            $display("FAIL ovf_pos: lat=%0d DIFF=%b Bout=%b ovf=%b, expected 5 1111 1 1", lat, d, bo, ov);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.start = 1'b1;
        bus.A     = 4'b0101;
        bus.B     = 4'b0011;
        bus.Bin   = 1'b0;
        tick();
        // Keep start asserted with new operands; ignored until IDLE.
        bus.A = 4'b1111;
        bus.B = 4'b0000;
        lat   = 1;
        while (bus.valid !== 1'b1 && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
        checks++;
        if (lat !== 5 || bus.DIFF !== 4'b0010 || bus.Bout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d DIFF=%b Bout=%b ovf=%b, expected 5 0010 0 0",
                     lat, bus.DIFF, bus.Bout, bus.ovf);
        end
        tick();
        checks++;
        if (bus.ready !== 1'b1 || bus.valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_ready_after_done: ready=%b valid=%b, expected 1 0", bus.ready, bus.valid);
        end
        lat = 1;
        while (bus.valid !== 1'b1 && lat < MAX_WAIT) begin
            tick();
            lat++;
        end
        bus.start = 1'b0;
        checks++;
        if (lat !== 6 || bus.DIFF !== 4'b1111 || bus.Bout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: valid-to-valid=%0d DIFF=%b Bout=%b ovf=%b, expected 6 1111 0 0",
                     lat, bus.DIFF, bus.Bout, bus.ovf);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        logic [WIDTH-1:0] d;
        logic bo, ov;
        bus.start = 1'b1;
        bus.A     = 4'b1001;
        bus.B     = 4'b0001;
        bus.Bin   = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.ready !== 1'b1 || bus.valid !== 1'b0 || bus.DIFF !== 4'b0000 ||
            bus.Bout !== 1'b0 || bus.ovf !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_state: ready=%b valid=%b DIFF=%b Bout=%b ovf=%b, expected 1 0 0000 0 0",
                     bus.ready, bus.valid, bus.DIFF, bus.Bout, bus.ovf);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.valid === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midrun_no_valid: saw %0d valid cycles, expected 0", seen);
        end
        do_op(4'b1001, 4'b0001, 1'b0, lat, d, bo, ov);
        checks++;
        if (lat !== 5 || d !== 4'b1000 || bo !== 1'b0 || ov !== 1'b0) begin
            errors++;
            $display("FAIL midrun_fresh_op: lat=%0d DIFF=%b Bout=%b ovf=%b, expected 5 1000 0 0", lat, d, bo, ov);
        end
        tick();
    endtask

    task automatic test_reset_with_start();
        int seen;
        tick();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.A     = 4'b0110;
        bus.B     = 4'b0001;
        bus.Bin   = 1'b0;
        tick();
        rst       = 1'b0;
        bus.start = 1'b0;
        checks++;
        if (bus.ready !== 1'b1 || bus.DIFF !== 4'b0000) begin
            errors++;
            $display("FAIL rst_start_priority: ready=%b DIFF=%b, expected 1 0000", bus.ready, bus.DIFF);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.valid === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_start_no_valid: saw %0d valid cycles, expected 0", seen);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_overflow();
        test_back_to_back();
        test_reset_mid_run();
        test_reset_with_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
